// File: rtl/fb_pkg.sv
// Shared types for the frame-buffer pixel writer: screen geometry, the queued
// pixel record and the write-FSM states.
package fb_pkg;
   localparam int FB_SCREEN_W = 320;
   localparam int FB_SCREEN_H = 240;
   localparam int FB_ADDR_W   = 17;

   typedef logic [FB_ADDR_W-1:0] fb_addr_t;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic [6:0] color;
   } pixel_t;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } wr_state_t;
endpackage

// File: rtl/fb_pixel_writer_fifo.sv
// Small synchronous FIFO of pixel records. Head is the oldest entry; push
// into a full FIFO or pop from an empty one is ignored.
module pixel_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   push,
   input  pixel_t push_data,
   input  logic   pop,
   output logic   full,
   output logic   empty,
   output pixel_t head
);
   localparam int PW = $clog2(DEPTH);

   pixel_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW:0]     count;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   // NOTE: storage is not reset; entries are only read after a push has written them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/fb_pixel_writer.sv
// Sprite pixel sink: clips and drops transparent pixels, queues the rest and
// writes them to the frame buffer with a we/ack handshake, reporting per-sprite counts.
module fb_pixel_writer
   import fb_pkg::*;
#(
   parameter int         SCREEN_W    = FB_SCREEN_W,
   parameter int         SCREEN_H    = FB_SCREEN_H,
   parameter logic [6:0] TRANSPARENT = 7'h00,
   parameter int         FIFO_DEPTH  = 8,
   parameter int         ADDR_W      = FB_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [8:0]        in_x,
   input  logic [7:0]        in_y,
   input  logic [6:0]        in_color,
   input  logic              in_last,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [6:0]        mem_data,
   output logic              mem_we,
   input  logic              mem_ack,
   output logic              frame_done,
   output logic [ADDR_W-1:0] px_written,
   output logic [ADDR_W-1:0] px_dropped
);
   wr_state_t         state;
   pixel_t            in_pix;
   pixel_t            head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              accept;
   logic              keep;
   logic              push;
   logic              pop;
   logic              drop_evt;
   logic              wr_evt;
   logic              done_cond;
   logic              pending_last;
   logic [ADDR_W-1:0] head_addr;

   assign in_ready = !fifo_full && !reset;
   assign accept   = in_valid && in_ready;
   assign keep     = (int'(in_x) < SCREEN_W) && (int'(in_y) < SCREEN_H)
                     && (in_color != TRANSPARENT);
   assign push     = accept && keep;
   assign drop_evt = accept && !keep;
   assign in_pix   = '{x: in_x, y: in_y, color: in_color};

   // A write commits only while the request is actually up; stray acks in IDLE are ignored.
   assign wr_evt    = (state == WRITE) && mem_ack;
   assign pop       = !fifo_empty && ((state == IDLE) || wr_evt);
   assign done_cond = pending_last && fifo_empty && (state == IDLE) && !accept;

   // Constant multiply folds into shift-adds ((y<<8)+(y<<6) for a 320-wide screen).
   assign head_addr = ADDR_W'(head.y) * ADDR_W'(SCREEN_W) + ADDR_W'(head.x);

   pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (in_pix),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
      end else if (pop) begin
         state    <= WRITE;
         mem_we   <= 1'b1;
         mem_addr <= head_addr;
         mem_data <= head.color;
      end else if (wr_evt) begin
         state    <= IDLE;
         mem_we   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_last <= 1'b0;
         frame_done   <= 1'b0;
         px_written   <= '0;
         px_dropped   <= '0;
      end else begin
         frame_done <= done_cond;
         if (accept && in_last) pending_last <= 1'b1;
         else if (done_cond)    pending_last <= 1'b0;

         // Counters restart at the sprite boundary and saturate instead of wrapping.
         if (done_cond)                        px_written <= ADDR_W'(wr_evt);
         else if (wr_evt && px_written != '1)  px_written <= px_written + ADDR_W'(1);

         if (done_cond)                        px_dropped <= ADDR_W'(drop_evt);
         else if (drop_evt && px_dropped != '1) px_dropped <= px_dropped + ADDR_W'(1);
      end
   end
endmodule
